// File: rtl/lsu_mem_adapter.sv
// MEM-stage load/store adapter: byte-addressed core accesses to a word-addressed SRAM
// over req/ack, with lane steering, load extension, misalignment and timeout reporting.
module lsu_mem_adapter #(
  parameter int unsigned TIMEOUT_CYCLES = 64,
  parameter int unsigned MEM_AW         = 30
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cpu_mem_read,
  input  logic [1:0]        cpu_mem_write,
  input  logic [1:0]        cpu_load_size,
  input  logic              cpu_load_unsigned,
  input  logic [31:0]       cpu_addr,
  input  logic [31:0]       cpu_wdata,
  output logic              cpu_stall,
  output logic [31:0]       cpu_rdata,
  output logic              cpu_rdata_valid,
  output logic              misalign_err,
  output logic              bus_err,
  output logic              mem_req,
  output logic              mem_we,
  output logic [3:0]        mem_be,
  output logic [MEM_AW-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  input  logic [31:0]       mem_rdata,
  input  logic              mem_ack
);

  localparam int unsigned      CNT_W    = 8;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
  localparam logic [1:0]       SZ_B     = 2'd0;
  localparam logic [1:0]       SZ_H     = 2'd1;
  localparam logic [1:0]       SZ_W     = 2'd2;

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_DONE, S_ERR} state_t;

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q;
  logic [MEM_AW-1:0] addr_q;
  logic [1:0]        lane_q, size_q;
  logic              uns_q, we_q, timeout_q;
  logic [3:0]        be_q;
  logic [31:0]       wdata_q, rdata_q;

  logic              store, op, misal, accept;
  logic [1:0]        size, lane;
  logic [3:0]        be;
  logic [31:0]       wdata, load_ext;
  logic [7:0]        sel_byte;
  logic [15:0]       sel_half;

  // Request decode: a store wins over a simultaneous read; size codes shared by both.
  always_comb begin
    store   = cpu_mem_write != 2'b00;
    op      = cpu_mem_read | store;
    lane    = cpu_addr[1:0];
    size    = SZ_W;
    be      = 4'b1111;
    wdata   = 32'h0;
    if (store) begin
      size = cpu_mem_write - 2'd1;
    end else if (cpu_load_size != 2'b11) begin
      size = cpu_load_size;
    end
    misal = ((size == SZ_H) && lane[0]) || ((size == SZ_W) && (lane != 2'b00));
    if (store) begin
      case (size)
        SZ_B: begin
          be    = 4'b0001 << lane;
          wdata = {4{cpu_wdata[7:0]}};
        end
        SZ_H: begin
          be    = 4'b0011 << lane;
          wdata = {2{cpu_wdata[15:0]}};
        end
        default: wdata = cpu_wdata;
      endcase
    end
  end

  // Load extraction from the returned word using the latched lane/size.
  always_comb begin
    case (lane_q)
      2'd0:    sel_byte = mem_rdata[7:0];
      2'd1:    sel_byte = mem_rdata[15:8];
      2'd2:    sel_byte = mem_rdata[23:16];
      default: sel_byte = mem_rdata[31:24];
    endcase
    sel_half = lane_q[1] ? mem_rdata[31:16] : mem_rdata[15:0];
    case (size_q)
      SZ_B:    load_ext = uns_q ? {24'h0, sel_byte} : {{24{sel_byte[7]}}, sel_byte};
      SZ_H:    load_ext = uns_q ? {16'h0, sel_half} : {{16{sel_half[15]}}, sel_half};
      default: load_ext = mem_rdata;
    endcase
  end

  // Next-state and the combinational stall.
  always_comb begin
    state_d   = state_q;
    cpu_stall = 1'b0;
    accept    = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (op) begin
          cpu_stall = 1'b1;
          accept    = !misal;
          state_d   = misal ? S_ERR : S_WAIT;
        end
      end
      S_WAIT: begin
        cpu_stall = 1'b1;
        if (mem_ack || (cnt_q == CNT_LAST)) state_d = S_DONE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      addr_q    <= '0;
      lane_q    <= '0;
      size_q    <= '0;
      uns_q     <= 1'b0;
      we_q      <= 1'b0;
      timeout_q <= 1'b0;
      be_q      <= '0;
      wdata_q   <= '0;
      rdata_q   <= '0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        addr_q  <= cpu_addr[MEM_AW+1:2];
        lane_q  <= lane;
        size_q  <= size;
        uns_q   <= cpu_load_unsigned;
        we_q    <= store;
        be_q    <= be;
        wdata_q <= wdata;
        cnt_q   <= '0;
      end
      if (state_q == S_WAIT) begin
        cnt_q <= cnt_q + 1'b1;
        if (mem_ack) begin
          rdata_q   <= load_ext;
          timeout_q <= 1'b0;
        end else if (cnt_q == CNT_LAST) begin
          rdata_q   <= '0;
          timeout_q <= 1'b1;
        end
      end
    end
  end

  // Outputs decode directly from registered state.
  assign mem_req         = state_q == S_WAIT;
  assign mem_we          = we_q;
  assign mem_be          = be_q;
  assign mem_addr        = addr_q;
  assign mem_wdata       = wdata_q;
  assign cpu_rdata_valid = state_q == S_DONE;
  assign bus_err         = (state_q == S_DONE) && timeout_q;
  assign misalign_err    = state_q == S_ERR;
  assign cpu_rdata       = (state_q == S_ERR) ? 32'h0 : rdata_q;

endmodule

// File: doc/lsu_mem_adapter.md
Name: lsu_mem_adapter

Overview:
- Load/store adapter in the MEM stage, between the pipelined RV32I core and the word-addressed data SRAM.
- Converts the core's read/write request (size, address, store data) into a word-addressed request with byte enables and lane-aligned write data, using a req/ack handshake.
- Returns sign- or zero-extended load data and stalls the pipeline until the access completes.
- Also flags misaligned accesses and memory timeouts.

Parameters:
- TIMEOUT_CYCLES, 64: cycles to wait for mem_ack before aborting with bus_err; legal range 2..255.
- MEM_AW, 30: word-address width driven to the SRAM.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- cpu_mem_read  in  1  load request this cycle.
- cpu_mem_write  in  2  store size: 00 none, 01 byte, 10 half, 11 word.
- cpu_load_size  in  2  load size: 00 byte, 01 half, 10 word (11 treated as word).
- cpu_load_unsigned  in  1  1 = zero-extend load (lbu/lhu).
- cpu_addr  in  32  byte address (ALU result).
- cpu_wdata  in  32  store data (rs2).
- cpu_stall  out  1  hold the pipeline.
- cpu_rdata  out  32  extended load data.
- cpu_rdata_valid  out  1  one-cycle pulse: access complete.
- misalign_err  out  1  one-cycle pulse: misaligned access rejected.
- bus_err  out  1  one-cycle pulse: timeout.
- mem_req  out  1  request to SRAM.
- mem_we  out  1  1 = write.
- mem_be  out  4  byte enables.
- mem_addr  out  MEM_AW  cpu_addr[MEM_AW+1:2].
- mem_wdata  out  32  lane-aligned store data.
- mem_rdata  in  32  SRAM read word.
- mem_ack  in  1  SRAM completion, sampled on clk.

Behaviour:
- Reset values: all outputs 0; state IDLE; timeout counter 0.
- Reset mid-access returns to IDLE at that edge. mem_req is low the next cycle, and no rdata_valid or error pulse is produced.
- Operation present: op = cpu_mem_read | (cpu_mem_write != 0).
- Read and write both asserted: the access is treated as a store and the read is ignored.
- States: IDLE, WAIT, DONE, ERR.
- IDLE, op with legal alignment:
  - Latch address, size, signedness, we, be and wdata.
  - Go to WAIT.
  - cpu_stall = 1 combinationally in this cycle.
- IDLE, op misaligned (half with addr[0]=1; word with addr[1:0]!=0):
  - Go to ERR; cpu_stall = 1 this cycle.
  - No memory access is issued.
- ERR: misalign_err = 1, cpu_stall = 0; next state IDLE. No register writeback data (cpu_rdata = 0, rdata_valid = 0).
- WAIT:
  - mem_req = 1 with the latched fields; cpu_stall = 1; counter increments each cycle.
  - mem_ack = 1: capture mem_rdata and go to DONE.
  - Counter reaches TIMEOUT_CYCLES-1 without ack: go to DONE with bus_err set.
- DONE (one cycle): cpu_stall = 0, mem_req = 0, cpu_rdata_valid = 1. bus_err = 1 if the access timed out, with cpu_rdata = 0. Next state IDLE.
- The core's request is still visible during DONE and ERR; it is ignored. A new request is accepted only in IDLE.
- mem_ack while not in WAIT is ignored.
- Minimum latency, ack on the first WAIT cycle: accept in cycle T, mem_req in T+1, rdata_valid in T+2 (2 stall cycles).
- Store lanes (lane = addr[1:0]):
  - Byte: wdata[7:0] replicated on all 4 lanes; be = 4'b0001 << lane.
  - Half: wdata[15:0] replicated on both halves; be = 4'b0011 << lane.
  - Word: wdata unchanged; be = 4'b1111.
- Loads:
  - mem_be = 4'b1111, mem_we = 0.
  - Result = selected byte or half of the captured word, shifted to bit 0.
  - Sign-extended unless cpu_load_unsigned = 1.
  - Word loads ignore cpu_load_unsigned.
- cpu_rdata holds its value until the next DONE; the valid signal is the rdata_valid pulse.

Test Plan:
- Store word 0x0000000F at addr 0x400, ack on first WAIT cycle -> mem_addr 0x100, be 1111, we 1, mem_req high exactly 1 cycle, cpu_stall high 2 cycles.
- Store byte 0xA5 at 0x403 -> be 1000, mem_wdata 0xA5A5A5A5. Store half 0x1234 at 0x402 -> be 1100, wdata 0x12341234.
- Load byte at 0x461, mem_rdata 0x0000_80FF, ack after 3 WAIT cycles:
  - signed -> cpu_rdata 0xFFFFFF80, rdata_valid pulse 1 cycle.
  - repeat unsigned -> 0x00000080.
- Load word at 0x462 -> misalign_err pulse, mem_req never asserted, stall 1 cycle. Half at 0x461 -> same.
- Load with mem_ack held low -> bus_err and rdata_valid after exactly TIMEOUT_CYCLES WAIT cycles, cpu_rdata 0.
- Reset in the second WAIT cycle -> next cycle mem_req 0, cpu_stall 0, no pulses. A late mem_ack after reset is ignored; the next store proceeds normally.
